// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Entries are sized for the widest legal configuration; callers cast to their real widths.
package bp_pkg;

    localparam int unsigned BP_XLEN_MAX = 64;
    localparam int unsigned BP_TAG_MAX  = 32;
    localparam int unsigned BP_CTR_MAX  = 4;

    // Named states of the 2-bit direction counter
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_MAX-1:0]  tag;
        logic [BP_XLEN_MAX-1:0] target;
        logic                   jump;
        logic [BP_CTR_MAX-1:0]  ctr;
    } bp_entry_t;

    // Word-aligned PC bits just above the byte offset select the entry
    function automatic logic [31:0] bp_index(input logic [BP_XLEN_MAX-1:0] pc,
                                             input int unsigned idx_w);
        logic [BP_XLEN_MAX-1:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

    function automatic logic [BP_TAG_MAX-1:0] bp_tag(input logic [BP_XLEN_MAX-1:0] pc,
                                                     input int unsigned idx_w,
                                                     input int unsigned tag_w);
        logic [BP_XLEN_MAX-1:0] mask;
        mask = (64'd1 << tag_w) - 64'd1;
        return BP_TAG_MAX'((pc >> (idx_w + 2)) & mask);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one saturating direction counter.
// Priority: set_max, then set_weak, then inc, then dec.
module bp_sat_counter #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] cur,
    input  logic                inc,
    input  logic                dec,
    input  logic                set_max,
    input  logic                set_weak,
    output logic [CTR_BITS-1:0] nxt
);

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly taken: MSB set, all other bits clear
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    always_comb begin
        nxt = cur;
        if (set_max) begin
            nxt = CTR_MAX;
        end else if (set_weak) begin
            nxt = CTR_WEAK;
        end else if (inc && (cur != CTR_MAX)) begin
            nxt = cur + 1'b1;
        end else if (dec && (cur != '0)) begin
            nxt = cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, looked up from Fetch, trained from Execute.
// Optional BRANCH_PREDICTOR_PERF_CTR_EN adds lookup/mispredict event counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned TAG_BITS = 8,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            UpdValidE,
    input  logic [XLEN-1:0] UpdPCE,
    input  logic            UpdJumpE,
    input  logic            UpdTakenE,
    input  logic [XLEN-1:0] UpdTargetE,
    input  logic            FlushAllE
`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
    ,
    input  logic            UpdMispredE,
    output logic [31:0]     LookupCnt,
    output logic [31:0]     MispredCnt
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    bp_entry_t mem_q [ENTRIES];

    logic [IDX_W-1:0]      rd_idx, upd_idx;
    logic [BP_TAG_MAX-1:0] rd_tag, upd_tag;
    bp_entry_t             rd_ent, upd_ent, upd_new;
    logic                  rd_hit, upd_hit, upd_write;
    logic [CTR_BITS-1:0]   ctr_nxt;

    // Fetch-side lookup sees the registered array only, so same-cycle updates are not bypassed
    assign rd_idx      = IDX_W'(bp_index(BP_XLEN_MAX'(PCF), IDX_W));
    assign rd_tag      = bp_tag(BP_XLEN_MAX'(PCF), IDX_W, TAG_BITS);
    assign rd_ent      = mem_q[rd_idx];
    assign rd_hit      = rd_ent.valid && (rd_ent.tag == rd_tag);
    assign PredTakenF  = rd_hit && (rd_ent.jump || rd_ent.ctr[CTR_BITS-1]);
    assign PredTargetF = PredTakenF ? XLEN'(rd_ent.target) : '0;

    assign upd_idx   = IDX_W'(bp_index(BP_XLEN_MAX'(UpdPCE), IDX_W));
    assign upd_tag   = bp_tag(BP_XLEN_MAX'(UpdPCE), IDX_W, TAG_BITS);
    assign upd_ent   = mem_q[upd_idx];
    assign upd_hit   = upd_ent.valid && (upd_ent.tag == upd_tag);
    // Not-taken outcomes never allocate; a taken miss evicts whatever aliases there
    assign upd_write = UpdValidE && (upd_hit || UpdTakenE);

    bp_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter (
        .cur      (CTR_BITS'(upd_ent.ctr)),
        .inc      (upd_hit && !UpdJumpE && UpdTakenE),
        .dec      (upd_hit && !UpdJumpE && !UpdTakenE),
        .set_max  (UpdJumpE),
        .set_weak (!upd_hit && !UpdJumpE),
        .nxt      (ctr_nxt)
    );

    always_comb begin
        upd_new     = upd_ent;
        upd_new.ctr = BP_CTR_MAX'(ctr_nxt);
        if (!upd_hit) begin
            upd_new.valid  = 1'b1;
            upd_new.tag    = upd_tag;
            upd_new.target = BP_XLEN_MAX'(UpdTargetE);
            upd_new.jump   = UpdJumpE;
        end else if (UpdJumpE) begin
            upd_new.jump   = 1'b1;
            upd_new.target = BP_XLEN_MAX'(UpdTargetE);
        end else if (UpdTakenE) begin
            upd_new.target = BP_XLEN_MAX'(UpdTargetE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i] <= '0;
            end
        end else if (FlushAllE) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else if (upd_write) begin
            mem_q[upd_idx] <= upd_new;
        end
    end

`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
    // Event counters survive FlushAllE; only reset clears them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            LookupCnt  <= '0;
            MispredCnt <= '0;
        end else if (UpdValidE) begin
            LookupCnt <= LookupCnt + 32'd1;
            if (UpdMispredE) begin
                MispredCnt <= MispredCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor (ENTRIES=64, TAG_BITS=8, CTR_BITS=2).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdValidE;
    logic [31:0] UpdPCE;
    logic        UpdJumpE;
    logic        UpdTakenE;
    logic [31:0] UpdTargetE;
    logic        FlushAllE;
`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
    logic        UpdMispredE;
    logic [31:0] LookupCnt;
    logic [31:0] MispredCnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN     (32),
        .ENTRIES  (64),
        .TAG_BITS (8),
        .CTR_BITS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .UpdValidE   (UpdValidE),
        .UpdPCE      (UpdPCE),
        .UpdJumpE    (UpdJumpE),
        .UpdTakenE   (UpdTakenE),
        .UpdTargetE  (UpdTargetE),
        .FlushAllE   (FlushAllE)
`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
        ,
        .UpdMispredE (UpdMispredE),
        .LookupCnt   (LookupCnt),
        .MispredCnt  (MispredCnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_tgt);
        PCF = pc;
        #1;
        check_eq({tag, "_taken"}, 64'(PredTakenF), 64'(exp_taken));
        check_eq({tag, "_target"}, 64'(PredTargetF), 64'(exp_tgt));
    endtask

    // Presents one resolved outcome for exactly one rising edge
    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                       input logic [31:0] tgt, input logic misp);
        UpdValidE  = 1'b1;
        UpdPCE     = pc;
        UpdJumpE   = jmp;
        UpdTakenE  = tkn;
        UpdTargetE = tgt;
`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
        UpdMispredE = misp;
`else
        if (misp) begin end
`endif
        @(posedge clk);
        #1;
        UpdValidE = 1'b0;
`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
        UpdMispredE = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        PCF = 32'h100;
        UpdValidE = 1'b0;
        UpdPCE = '0;
        UpdJumpE = 1'b0;
        UpdTakenE = 1'b0;
        UpdTargetE = '0;
        FlushAllE = 1'b0;
`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
        UpdMispredE = 1'b0;
`endif
        repeat (2) @(posedge clk);
        look("reset", 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Same-cycle allocate on 0x100: old (empty) entry seen until the edge
        PCF = 32'h100;
        UpdValidE = 1'b1; UpdPCE = 32'h100; UpdJumpE = 1'b0; UpdTakenE = 1'b1;
        UpdTargetE = 32'h80;
        #1;
        check_eq("same_cycle_pre", 64'(PredTakenF), 64'd0);
        @(posedge clk);
        #1;
        UpdValidE = 1'b0;
        look("alloc_wt", 32'h100, 1'b1, 32'h80);

        upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b1);
        look("wnt", 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 1'b1, 32'h90, 1'b1);
        look("wt_new_target", 32'h100, 1'b1, 32'h90);
        upd(32'h100, 1'b0, 1'b1, 32'h90, 1'b0);
        upd(32'h100, 1'b0, 1'b1, 32'h90, 1'b0);
        upd(32'h100, 1'b0, 1'b0, 32'hFF0, 1'b1);
        look("st_to_wt", 32'h100, 1'b1, 32'h90);
        upd(32'h100, 1'b0, 1'b0, 32'hFF0, 1'b1);
        look("wt_to_wnt", 32'h100, 1'b0, 32'h0);

        // Upd* contents are ignored without UpdValidE
        UpdPCE = 32'h100; UpdTakenE = 1'b1; UpdTargetE = 32'h123;
        @(posedge clk);
        #1;
        look("no_valid", 32'h100, 1'b0, 32'h0);

        upd(32'h20, 1'b0, 1'b0, 32'h30, 1'b1);
        look("nt_no_alloc", 32'h20, 1'b0, 32'h0);

        // Alias: 0x200 shares index 0 with 0x100, different tag
        upd(32'h100, 1'b0, 1'b1, 32'h90, 1'b1);
        look("retrain", 32'h100, 1'b1, 32'h90);
        upd(32'h200, 1'b0, 1'b1, 32'h40, 1'b1);
        look("alias_evicted", 32'h100, 1'b0, 32'h0);
        look("alias_hit", 32'h200, 1'b1, 32'h40);

        upd(32'h10, 1'b1, 1'b1, 32'h400, 1'b1);
        look("jal", 32'h10, 1'b1, 32'h400);
        for (int i = 0; i < 4; i++) begin
            upd(32'h10, 1'b1, 1'b0, 32'h400, 1'b0);
        end
        look("jal_sticky", 32'h10, 1'b1, 32'h400);

        // Flush wins over a simultaneous allocate
        FlushAllE = 1'b1;
        upd(32'h300, 1'b0, 1'b1, 32'h500, 1'b1);
        FlushAllE = 1'b0;
        look("flush_jal", 32'h10, 1'b0, 32'h0);
        look("flush_alias", 32'h200, 1'b0, 32'h0);
        look("flush_drop", 32'h300, 1'b0, 32'h0);

        // Asynchronous reset mid-operation
        upd(32'h44, 1'b0, 1'b1, 32'h88, 1'b1);
        look("pre_reset", 32'h44, 1'b1, 32'h88);
        @(negedge clk);
        rst = 1'b0;
        #1;
        look("async_reset", 32'h44, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        upd(32'h44, 1'b0, 1'b1, 32'h88, 1'b1);
        look("first_after_reset", 32'h44, 1'b1, 32'h88);
        upd(32'h44, 1'b0, 1'b1, 32'h88, 1'b0);
        upd(32'h48, 1'b0, 1'b0, 32'h0, 1'b0);
        look("nt_miss_48", 32'h48, 1'b0, 32'h0);
        upd(32'h48, 1'b0, 1'b1, 32'hC0, 1'b1);
        upd(32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
        look("st_44_dec", 32'h44, 1'b1, 32'h88);
        look("wt_48", 32'h48, 1'b1, 32'hC0);
`ifdef BRANCH_PREDICTOR_PERF_CTR_EN
        check_eq("lookup_cnt", 64'(LookupCnt), 64'd5);
        check_eq("mispred_cnt", 64'(MispredCnt), 64'd2);
        FlushAllE = 1'b1;
        @(posedge clk);
        #1;
        FlushAllE = 1'b0;
        check_eq("lookup_cnt_flush", 64'(LookupCnt), 64'd5);
        check_eq("mispred_cnt_flush", 64'(MispredCnt), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
